// File: rtl/replay_restore_if.sv
// Replay-restore bus: controller stream in, golden read port, target write port, status out.
interface replay_restore_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  halt;
    logic                  resume;
    logic [ADDR_WIDTH-1:0] replay_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  core_stall;
    logic                  restore_done;
    logic                  seq_err;
    logic [7:0]            restore_count;

    modport master (
        output halt, resume, replay_addr, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  core_stall, restore_done, seq_err, restore_count
    );

    modport slave (
        input  halt, resume, replay_addr, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data,
        output core_stall, restore_done, seq_err, restore_count
    );
endinterface

// File: rtl/replay_restore.sv
// Copies checkpoint registers into the faulty core's register file as the recovery
// controller announces them, keeping the core stalled from halt until resume.
//
// state       | meaning
// IDLE        | no recovery; core runs; waits for halt
// RESTORE     | following the announced address stream, one read/write per new address
// DRAIN       | final register write in flight
// WAIT_RESUME | all registers restored; waits for the controller's resume
module replay_restore #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input logic             clk,
    input logic             rst,
    replay_restore_if.slave bus
);
    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REG - 1);

    typedef enum logic [1:0] {IDLE, RESTORE, DRAIN, WAIT_RESUME} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  have_last;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  stall_q;
    logic                  done_q;
    logic                  err_q;
    logic [7:0]            count_q;

    logic in_order;
    logic holding;

    assign in_order = (bus.replay_addr == exp_addr);
    // A controller repeating the address it just announced is waiting, not skipping.
    assign holding  = have_last && (bus.replay_addr == last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exp_addr  <= '0;
            last_addr <= '0;
            have_last <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.halt) begin
                        state     <= RESTORE;
                        stall_q   <= 1'b1;
                        err_q     <= 1'b0;
                        exp_addr  <= '0;
                        have_last <= 1'b0;
                    end
                end
                RESTORE: begin
                    if (bus.resume) begin
                        state   <= IDLE;
                        stall_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (in_order) begin
                        // x0 is hardwired in the target, so its slot is consumed without a write.
                        wr_en_q   <= !(SKIP_ZERO && (bus.replay_addr == '0));
                        wr_addr_q <= bus.replay_addr;
                        last_addr <= bus.replay_addr;
                        have_last <= 1'b1;
                        exp_addr  <= exp_addr + 1'b1;
                        if (bus.replay_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end
                    end else if (!holding) begin
                        err_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= WAIT_RESUME;
                end
                WAIT_RESUME: begin
                    if (bus.resume) begin
                        state   <= IDLE;
                        stall_q <= 1'b0;
                        done_q  <= 1'b1;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The golden file has one cycle of read latency, so its data lines up with the
    // registered write strobe and can pass straight through.
    assign bus.rd_addr       = (state == RESTORE) ? bus.replay_addr : '0;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_en_q ? bus.rd_data : '0;
    assign bus.core_stall    = stall_q;
    assign bus.restore_done  = done_q;
    assign bus.seq_err       = err_q;
    assign bus.restore_count = count_q;
endmodule

// File: tb/tb_replay_restore.sv
// Randomized bench for replay_restore: per-session reference model of writes, done, errors and count.
module tb_replay_restore;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    replay_restore_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    replay_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_ZERO(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_count = 0;

    logic [DW-1:0] golden [NREG];
    int            stim [$];
    logic [63:0]   obs_w [$];
    logic [63:0]   exp_w [$];
    int            done_n;
    int            done_cyc;
    int            err_seen;
    bit            err_armed;

    always @(posedge clk) cyc <= cyc + 1;

    // golden register file: synchronous read, data valid one cycle after the address
    always @(posedge clk) bus.rd_data <= golden[bus.rd_addr];

    function automatic logic [63:0] pack(input int c, input int a, input logic [DW-1:0] d);
        return {16'(c), 11'd0, 5'(a), d};
    endfunction

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) obs_w.push_back(pack(cyc, int'(bus.wr_addr), bus.wr_data));
        if (bus.restore_done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err_armed && bus.seq_err === 1'b1 && err_seen < 0) err_seen = cyc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_golden(input bit fixed);
        for (int i = 0; i < NREG; i++) golden[i] = fixed ? (32'hA000_0000 + 32'(i)) : $urandom;
    endtask

    task automatic make_clean(input int hold_pct);
        stim.delete();
        for (int a = 0; a < NREG; a++) begin
            stim.push_back(a);
            if ($urandom_range(0, 99) < hold_pct) repeat ($urandom_range(1, 2)) stim.push_back(a);
        end
    endtask

    // Drives halt, the address stream in stim, then resume; predicts the outcome from the
    // address rules: in-order address issues, repeat of previous is a hold, anything else errors.
    task automatic run_session(input int gap);
        int  nxt = 0;
        int  last = -1;
        int  exp_err_cyc = -1;
        int  r;
        bit  complete = 1'b0;
        obs_w.delete();
        exp_w.delete();
        done_n    = 0;
        err_armed = 1'b0;
        err_seen  = -1;
        bus.halt        = 1'b1;
        bus.resume      = 1'($urandom_range(0, 1));
        bus.replay_addr = AW'($urandom);
        step();
        bus.resume = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            int a = stim[i];
            bus.halt        = ($urandom_range(0, 3) == 0);
            bus.replay_addr = AW'(a);
            err_armed       = 1'b1;
            if (!complete) begin
                if (a == nxt) begin
                    if (a != 0) exp_w.push_back(pack(cyc + 1, a, golden[a]));
                    last     = a;
                    nxt      = nxt + 1;
                    complete = (nxt == NREG);
                end else if (a != last) begin
                    if (exp_err_cyc < 0) exp_err_cyc = cyc + 1;
                end
            end
            if (i == 0) begin
                @(negedge clk);
                check("stall_on", bus.core_stall, 1);
            end
            step();
        end
        bus.halt = 1'b0;
        if (complete) repeat (1 + gap) step();
        else if (exp_err_cyc < 0) exp_err_cyc = cyc + 1;
        bus.resume = 1'b1;
        r = cyc;
        step();
        bus.resume = 1'b0;
        @(negedge clk);
        check("stall_off", bus.core_stall, 0);
        repeat (3) step();
        if (complete && exp_count < 255) exp_count++;
        check("n_writes", obs_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) check("write", obs_w[i], exp_w[i]);
        check("done_n", done_n, complete ? 1 : 0);
        if (complete) check("done_cyc", done_cyc, r + 1);
        check("err_first", err_seen, exp_err_cyc);
        check("seq_err", bus.seq_err, (exp_err_cyc >= 0) ? 1 : 0);
        check("count", bus.restore_count, exp_count);
    endtask

    initial begin
        rst             = 1'b1;
        bus.halt        = 1'b0;
        bus.resume      = 1'b0;
        bus.replay_addr = '0;
        err_armed       = 1'b0;
        err_seen        = -1;
        done_n          = 0;
        fill_golden(1'b1);
        repeat (3) step();
        @(negedge clk);
        check("rst_stall", bus.core_stall, 0);
        check("rst_done", bus.restore_done, 0);
        check("rst_err", bus.seq_err, 0);
        check("rst_count", bus.restore_count, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        step();
        rst = 1'b0;
        step();

        // clean recovery with fixed golden pattern
        make_clean(0);
        run_session(0);

        // controller holds 7 for three cycles
        fill_golden(1'b0);
        stim.delete();
        for (int a = 0; a < NREG; a++) begin
            stim.push_back(a);
            if (a == 7) begin
                stim.push_back(7);
                stim.push_back(7);
            end
        end
        run_session(1);

        // skipped address 3, then the controller gives up
        stim = '{0, 1, 2, 4};
        run_session(0);

        // premature resume after address 10
        stim.delete();
        for (int a = 0; a <= 10; a++) stim.push_back(a);
        run_session(0);

        // random mix of clean, skipping and truncated sessions
        for (int s = 0; s < 30; s++) begin
            int mode = $urandom_range(0, 2);
            int k;
            fill_golden(1'b0);
            if (mode == 0) begin
                make_clean(15);
            end else if (mode == 1) begin
                k = $urandom_range(1, 30);
                stim.delete();
                for (int a = 0; a < k; a++) stim.push_back(a);
                stim.push_back(k + 1);
                if ($urandom_range(0, 1) == 1) stim.push_back(k);
            end else begin
                k = $urandom_range(0, 30);
                stim.delete();
                for (int a = 0; a <= k; a++) stim.push_back(a);
            end
            run_session($urandom_range(0, 3));
        end

        // reset while address 15 is being presented
        fill_golden(1'b0);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        for (int a = 0; a < 15; a++) begin
            bus.replay_addr = AW'(a);
            step();
        end
        bus.replay_addr = AW'(15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("mid_rst_wr_en", bus.wr_en, 0);
        check("mid_rst_stall", bus.core_stall, 0);
        check("mid_rst_count", bus.restore_count, 0);
        step();
        make_clean(10);
        run_session(2);

        // saturation of the recovery counter
        for (int s = 0; s < 256; s++) begin
            fill_golden(1'b0);
            make_clean(5);
            run_session($urandom_range(0, 2));
        end
        check("count_sat", bus.restore_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
